// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master; serialises a val/rdy packet MSB-first and
// returns the word captured from MISO on a val/rdy response stream.
module spi_master_ctrl #(
   parameter int nbits    = 8,
   parameter int ncs      = 1,
   parameter int clk_half = 2
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [nbits-1:0]                      recv_msg,
   input  logic [(ncs > 1 ? $clog2(ncs) : 1)-1:0] recv_cs_addr,
   input  logic                                  recv_val,
   output logic                                  recv_rdy,
   output logic [nbits-1:0]                      send_msg,
   output logic                                  send_val,
   input  logic                                  send_rdy,
   output logic                                  spi_sclk,
   output logic [ncs-1:0]                        spi_cs,
   output logic                                  spi_mosi,
   input  logic                                  spi_miso
);
   localparam int CW = ncs > 1 ? $clog2(ncs) : 1;
   localparam int NW = $clog2(nbits + 1);
   localparam int DW = $clog2(clk_half + 1);

   typedef enum logic [2:0] {IDLE, START, HIGH, LOW, HOLD, DONE} state_t;

   state_t           state_q, state_d;
   logic [nbits-1:0] tx_q, tx_d, rx_q, rx_d;
   logic [NW-1:0]    cnt_q, cnt_d;
   logic [DW-1:0]    div_q, div_d;
   logic [CW-1:0]    cs_sel_q, cs_sel_d;
   logic             active, last;

   assign active = state_q inside {START, HIGH, LOW, HOLD};
   assign last   = div_q == DW'(clk_half - 1);

   always_comb begin
      state_d  = state_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      cnt_d    = cnt_q;
      cs_sel_d = cs_sel_q;
      div_d    = (active && !last) ? div_q + 1'b1 : '0;
      case (state_q)
         IDLE: if (recv_val) begin
            tx_d     = recv_msg;
            rx_d     = '0;
            cnt_d    = NW'(nbits);
            cs_sel_d = recv_cs_addr;
            state_d  = START;
         end
         START: if (last) state_d = HIGH;
         HIGH: if (last) begin
            rx_d  = {rx_q[nbits-2:0], spi_miso};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == NW'(1)) state_d = HOLD;
            else begin
               state_d = LOW;
               tx_d    = {tx_q[nbits-2:0], 1'b0};
            end
         end
         LOW:  if (last) state_d = HIGH;
         HOLD: if (last) state_d = DONE;
         DONE: if (send_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         tx_q     <= '0;
         rx_q     <= '0;
         cnt_q    <= '0;
         div_q    <= '0;
         cs_sel_q <= '0;
      end else begin
         state_q  <= state_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         cs_sel_q <= cs_sel_d;
      end
   end

   // recv_rdy is gated by reset so it drops while reset is held, not just after
   assign recv_rdy = state_q == IDLE && !reset;
   assign send_val = state_q == DONE;
   assign send_msg = send_val ? rx_q : '0;
   assign spi_sclk = state_q == HIGH;
   assign spi_mosi = active & tx_q[nbits-1];

   for (genvar i = 0; i < ncs; i++) begin : g_cs
      assign spi_cs[i] = !(active && cs_sel_q == CW'(i));
   end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: table-driven transfers with a response scoreboard, plus
// hand-written reset-abort and multi-CS sequences.
module tb_spi_master_ctrl;
   logic clk = 0, reset = 1;
   always #5 clk = ~clk;

   logic [7:0] a_msg = 0, a_smsg;
   logic [0:0] a_addr = 0;
   logic       a_val = 0, a_rdy, a_sval, a_srdy = 0, a_sclk, a_mosi, a_miso;
   logic [0:0] a_cs;
   int         mode = 0;
   assign a_miso = mode == 0 ? a_mosi : mode == 1;

   logic [7:0] b_msg = 0, b_smsg;
   logic [1:0] b_addr = 0;
   logic       b_val = 0, b_rdy, b_sval, b_srdy = 0, b_sclk, b_mosi;
   logic [3:0] b_cs;

   spi_master_ctrl #(.nbits(8), .ncs(1), .clk_half(2)) u_a (
      .clk(clk), .reset(reset), .recv_msg(a_msg), .recv_cs_addr(a_addr),
      .recv_val(a_val), .recv_rdy(a_rdy), .send_msg(a_smsg), .send_val(a_sval),
      .send_rdy(a_srdy), .spi_sclk(a_sclk), .spi_cs(a_cs), .spi_mosi(a_mosi),
      .spi_miso(a_miso));

   spi_master_ctrl #(.nbits(8), .ncs(4), .clk_half(1)) u_b (
      .clk(clk), .reset(reset), .recv_msg(b_msg), .recv_cs_addr(b_addr),
      .recv_val(b_val), .recv_rdy(b_rdy), .send_msg(b_smsg), .send_val(b_sval),
      .send_rdy(b_srdy), .spi_sclk(b_sclk), .spi_cs(b_cs), .spi_mosi(b_mosi),
      .spi_miso(b_mosi));

   typedef struct {
      logic [7:0] msg;
      int         mode;
      int         hold;
      logic [7:0] exp;
   } vec_t;

   vec_t       v[7];
   logic [7:0] q[$];
   int         n_cmp = 0, n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic accept_a(input logic [7:0] msg, input logic [7:0] exp);
      int g = 0;
      @(negedge clk);
      a_msg = msg;
      a_val = 1;
      while (!a_rdy && g < 100) begin
         @(negedge clk);
         g++;
      end
      check("accept_rdy", a_rdy, 1);
      q.push_back(exp);
      @(posedge clk);
      #1 a_val = 0;
   endtask

   task automatic run_a(input vec_t t);
      logic [7:0] bits = 0, e;
      logic       prev = 0;
      int         k = 0, edges = 0, csl = 0, rdyhi = 0, bad = 0;
      mode = t.mode;
      accept_a(t.msg, t.exp);
      while (!a_sval && k < 200) begin
         if (a_sclk && !prev) begin
            edges++;
            bits = {bits[6:0], a_mosi};
         end
         prev = a_sclk;
         if (!a_cs[0]) csl++;
         if (a_rdy) rdyhi++;
         @(posedge clk);
         #1 k++;
      end
      check("latency", k, 34);
      check("sclk_edges", edges, 8);
      check("mosi_bits", bits, t.msg);
      check("cs_low_cycles", csl, 34);
      check("rdy_busy", rdyhi, 0);
      for (int i = 0; i < t.hold; i++) begin
         @(posedge clk);
         #1 if (!a_sval || a_smsg !== t.exp || a_cs !== 1'b1 || a_rdy || a_mosi || a_sclk) bad++;
      end
      if (t.hold > 0) check("stall_stable", bad, 0);
      e = q.pop_front();
      check("send_msg", a_smsg, e);
      a_srdy = 1;
      @(posedge clk);
      #1 a_srdy = 0;
      check("idle_after", {a_sval, a_rdy}, 2'b01);
   endtask

   initial begin
      logic prev;
      int   k, edges, bad;
      v[0] = '{8'hA5, 0, 0, 8'hA5};
      v[1] = '{8'h00, 1, 0, 8'hFF};
      v[2] = '{8'hFF, 2, 0, 8'h00};
      v[3] = '{8'h3C, 0, 0, 8'h3C};
      v[4] = '{8'hC3, 0, 0, 8'hC3};
      v[5] = '{8'h96, 0, 10, 8'h96};
      v[6] = '{8'h5A, 0, 0, 8'h5A};
      #2;
      check("rst_rdy", a_rdy, 0);
      check("rst_val", a_sval, 0);
      check("rst_msg", a_smsg, 0);
      check("rst_pins", {a_sclk, a_cs, a_mosi}, 3'b010);
      check("rst_b_cs", b_cs, 4'hF);
      @(negedge clk) reset = 0;
      #1 check("rdy_after_rst", a_rdy, 1);
      for (int i = 0; i < 6; i++) run_a(v[i]);

      // abort during the fourth SCLK high phase
      mode = 0;
      accept_a(8'hE7, 8'hE7);
      void'(q.pop_back());
      prev = 0; edges = 0; k = 0;
      while (edges < 4 && k < 200) begin
         @(posedge clk);
         #1 k++;
         if (a_sclk && !prev) edges++;
         prev = a_sclk;
      end
      check("high_bit4", a_sclk, 1);
      reset = 1;
      #1;
      check("abort_pins", {a_sclk, a_cs, a_mosi}, 3'b010);
      check("abort_rdy_val", {a_rdy, a_sval}, 2'b00);
      @(negedge clk) reset = 0;
      #1 check("rdy_after_abort", a_rdy, 1);
      run_a(v[6]);

      // four chip selects, clk_half=1, address changed after accept
      @(negedge clk);
      b_msg = 8'h81;
      b_addr = 2;
      b_val = 1;
      check("b_rdy", b_rdy, 1);
      q.push_back(8'h81);
      @(posedge clk);
      #1 b_val = 0;
      b_addr = 1;
      k = 0; bad = 0;
      while (!b_sval && k < 100) begin
         if (b_cs !== 4'b1011) bad++;
         @(posedge clk);
         #1 k++;
      end
      check("b_latency", k, 17);
      check("b_cs_only2", bad, 0);
      check("b_cs_done", b_cs, 4'hF);
      check("b_msg", b_smsg, q.pop_front());
      b_srdy = 1;
      @(posedge clk);
      #1 b_srdy = 0;
      check("b_idle", b_rdy, 1);
      check("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
